uart_rx: RTL and testbench

- Serial receiver that feeds the control-panel block.
- Turns the RXD line into `rx_byte`/`rx_busy`. The panel starts a command when `rx_busy` falls.
- 8N1 framing, LSB first, one sample at the middle of each bit.
- Replaces the receive half of the generic UART at the panel. The transmit path is unchanged.

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx_sync2.sv | 24 ++
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the panel UART receiver: FSM state encoding and frame width.
package uart_rx_pkg;

  localparam int FRAME_W = 8;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser with asynchronous preset to 1; reusable for any idle-high input.
module uart_rx_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver for the control panel; samples each bit once at its centre.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int baud      = 9600,
  parameter int clk_speed = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rxd,
  output logic [FRAME_W-1:0] rx_byte,
  output logic               rx_busy,
  output logic               rx_done,
  output logic               frame_err
);

  localparam int BIT   = clk_speed / baud;
  localparam int HALF  = BIT / 2;
  localparam int CNT_W = $clog2(BIT);

  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

  logic rs;

  rx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bi_q, bi_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] byte_q, byte_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ferr_q, ferr_d;

  uart_rx_sync2 u_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (rxd),
    .q_o   (rs)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bi_q    <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bi_q    <= bi_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    bi_d    = bi_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;

    unique case (state_q)
      RX_IDLE: begin
        if (!rs) begin
          cnt_d   = HALF_M1;
          state_d = RX_START;
        end
      end

      // Mid-start-bit recheck rejects glitches shorter than half a bit.
      RX_START: begin
        if (cnt_q == '0) begin
          if (!rs) begin
            busy_d  = 1'b1;
            cnt_d   = BIT_M1;
            bi_d    = '0;
            state_d = RX_DATA;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end

      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rs, shift_q[FRAME_W-1:1]};
          cnt_d   = BIT_M1;
          if (bi_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bi_d = bi_q + 3'd1;
          end
        end
      end

      // A bad stop bit delivers 0x00 so the panel never replays the previous command.
      RX_STOP: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          if (rs) begin
            byte_d  = shift_q;
            busy_d  = 1'b0;
            ferr_d  = 1'b0;
            state_d = RX_IDLE;
          end else begin
            byte_d  = '0;
            ferr_d  = 1'b1;
            state_d = RX_BREAK;
          end
        end
      end

      RX_BREAK: begin
        if (rs) begin
          busy_d  = 1'b0;
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign rx_byte   = byte_q;
  assign rx_busy   = busy_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx with BIT=16, HALF=8: directed frames, glitch, break, back-to-back, reset.
module tb_uart_rx;

  localparam int CLK_SPEED = 160;
  localparam int BAUD      = 10;
  localparam int BIT       = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_byte;
  logic       rx_busy;
  logic       rx_done;
  logic       frame_err;

  always #5 clk = ~clk;

  uart_rx #(.baud(BAUD), .clk_speed(CLK_SPEED)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_byte   (rx_byte),
    .rx_busy   (rx_busy),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [8:0] exp_q[$];  // {frame_err, rx_byte}
  logic [8:0] mon_e;

  int   done_cnt = 0, rise_cnt = 0, fall_cnt = 0;
  int   rise_cyc = 0, fall_cyc = 0, done_cyc = 0, prev_done_cyc = 0;
  logic prev_busy = 1'b0, prev_done = 1'b0;
  int   start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Monitor: sample away from the active edge, pop the scoreboard on each rx_done.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_busy && !prev_busy) begin
        rise_cnt++;
        rise_cyc = cyc;
      end
      if (!rx_busy && prev_busy) begin
        fall_cnt++;
        fall_cyc = cyc;
      end
      if (rx_done) begin
        if (prev_done) begin
          check("rx_done single cycle", {31'd0, prev_done}, 32'd0);
        end else begin
          done_cnt++;
          prev_done_cyc = done_cyc;
          done_cyc      = cyc;
          if (exp_q.size() == 0) begin
            check("rx_done with empty scoreboard", exp_q.size(), 32'd1);
          end else begin
            mon_e = exp_q.pop_front();
            check("rx_byte at rx_done", {24'd0, rx_byte}, {24'd0, mon_e[7:0]});
            check("frame_err at rx_done", {31'd0, frame_err}, {31'd0, mon_e[8]});
          end
        end
      end
      prev_busy = rx_busy;
      prev_done = rx_done;
    end
  end

  task automatic hold(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic [8:0] exp);
    exp_q.push_back(exp);
    start_cyc = cyc;
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(d[i], BIT);
    hold(stop, BIT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, f0, d0, rel;
    rxd   = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset rx_byte", {24'd0, rx_byte}, 32'h00);
    check("reset rx_busy", {31'd0, rx_busy}, 32'd0);
    check("reset rx_done", {31'd0, rx_done}, 32'd0);
    check("reset frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    hold(1'b1, 10);

    // Glitch shorter than HALF: no activity at all.
    r0 = rise_cnt; d0 = done_cnt;
    hold(1'b0, 5);
    hold(1'b1, 30);
    check("glitch busy rises", rise_cnt - r0, 0);
    check("glitch rx_done count", done_cnt - d0, 0);
    check("glitch rx_byte", {24'd0, rx_byte}, 32'h00);

    // Single valid frame 0x55.
    r0 = rise_cnt; f0 = fall_cnt; d0 = done_cnt;
    send(8'h55, 1'b1, {1'b0, 8'h55});
    hold(1'b1, 4);
    check_range("0x55 busy rise latency", rise_cyc - start_cyc, 10, 11);
    check_range("0x55 busy fall latency", fall_cyc - start_cyc, 154, 155);
    check_range("0x55 rx_done latency", done_cyc - start_cyc, 154, 155);
    check("0x55 rx_done count", done_cnt - d0, 1);
    check("0x55 busy falls", fall_cnt - f0, 1);

    // Framing error then held break.
    r0 = rise_cnt; f0 = fall_cnt; d0 = done_cnt;
    send(8'hA3, 1'b0, {1'b1, 8'h00});
    hold(1'b0, 40);
    check("break rx_done count", done_cnt - d0, 1);
    check("break rx_byte", {24'd0, rx_byte}, 32'h00);
    check("break frame_err", {31'd0, frame_err}, 32'd1);
    check("break busy held", {31'd0, rx_busy}, 32'd1);
    rel = cyc;
    hold(1'b1, 8);
    check_range("break busy fall after release", fall_cyc - rel, 2, 3);
    check("break busy falls", fall_cnt - f0, 1);
    check("break busy rises", rise_cnt - r0, 1);
    check("break rx_done still one", done_cnt - d0, 1);
    send(8'h21, 1'b1, {1'b0, 8'h21});
    hold(1'b1, 4);
    check("after break frame_err cleared", {31'd0, frame_err}, 32'd0);
    check("after break rx_byte", {24'd0, rx_byte}, 32'h21);

    // Back-to-back frames with no idle bits.
    r0 = rise_cnt; f0 = fall_cnt; d0 = done_cnt;
    send(8'h2B, 1'b1, {1'b0, 8'h2B});
    send(8'hE9, 1'b1, {1'b0, 8'hE9});
    hold(1'b1, 4);
    check("b2b rx_done count", done_cnt - d0, 2);
    check_range("b2b rx_done spacing", done_cyc - prev_done_cyc, 159, 161);
    check("b2b busy rises", rise_cnt - r0, 2);
    check("b2b busy falls", fall_cnt - f0, 2);

    // Reset in the middle of bit 4 of 0xFF.
    d0 = done_cnt;
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(1'b1, BIT);
    hold(1'b1, BIT / 2);
    check("pre-reset busy", {31'd0, rx_busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid-frame reset rx_busy", {31'd0, rx_busy}, 32'd0);
    check("mid-frame reset rx_byte", {24'd0, rx_byte}, 32'h00);
    check("mid-frame reset frame_err", {31'd0, frame_err}, 32'd0);
    check("mid-frame reset rx_done", {31'd0, rx_done}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    hold(1'b1, 40);
    check("reset frame no rx_done", done_cnt - d0, 0);
    send(8'h0F, 1'b1, {1'b0, 8'h0F});
    hold(1'b1, 4);
    check("post-reset rx_byte", {24'd0, rx_byte}, 32'h0F);

    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
